// File: rtl/launch_ctrl_pkg.sv
// launch_ctrl_pkg: shared game types and widths for the launch stage and ball block.
//   state_t    FSM states AIM/POWER/LAUNCH/ROLL (2-bit)
//   AIM_W      signed aim width
//   POWER_W    power width
//   SPEED_W    speed bus width, shared with the ball block
//   launch_vy  vertical speed from aim and power
package launch_ctrl_pkg;
   typedef enum logic [1:0] {AIM = 2'd0, POWER = 2'd1, LAUNCH = 2'd2, ROLL = 2'd3} state_t;
   localparam int AIM_W   = 5;
   localparam int POWER_W = 5;
   localparam int SPEED_W = 16;
   // (|aim| * power) >> 2, formed at 10 bits then zero-extended onto the speed bus
   function automatic logic [SPEED_W-1:0] launch_vy(input logic signed [AIM_W-1:0] aim,
                                                    input logic [POWER_W-1:0] power);
      logic [AIM_W-1:0] mag;
      logic [9:0] prod;
      mag  = aim[AIM_W-1] ? -aim : aim;
      prod = 10'(mag) * 10'(power);
      return SPEED_W'(prod >> 2);
   endfunction
endpackage

// File: rtl/launch_ctrl_if.sv
// launch_ctrl_if: launch request bus between launch_ctrl (master) and the ball block (slave).
//   speed_x_out    horizontal speed
//   speed_y_out    vertical speed magnitude
//   is_vy_neg_out  1 = upward
//   valid_out      launch request, held long enough to span one ball tick
//   ball_done_in   ball finished rolling
interface launch_ctrl_if;
   import launch_ctrl_pkg::*;
   logic [SPEED_W-1:0] speed_x_out;
   logic [SPEED_W-1:0] speed_y_out;
   logic               is_vy_neg_out;
   logic               valid_out;
   logic               ball_done_in;
   modport master (output speed_x_out, speed_y_out, is_vy_neg_out, valid_out, input ball_done_in);
   modport slave  (input speed_x_out, speed_y_out, is_vy_neg_out, valid_out, output ball_done_in);
endinterface

// File: rtl/launch_ctrl_btn_debounce.sv
// launch_ctrl_btn_debounce: button synchronizer, optional debounce and rising-edge press pulse.
//   clk_in  clock
//   rst_in  asynchronous active-low reset
//   btn     raw asynchronous button, active-high
//   press   one-cycle pulse per accepted press
// Macro LAUNCH_CTRL_DEBOUNCE_EN enables the debounce counter; otherwise the
// edge detector sees the synchronizer output directly.
module launch_ctrl_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic btn,
   output logic press
);
   logic s0, s1, lvl, lvl_q;
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
`ifdef LAUNCH_CTRL_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt;
   // accept a new level only after it differs from the held one for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt <= '0;
         lvl <= 1'b0;
      end else if (s1 == lvl) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt <= '0;
         lvl <= s1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign lvl = s1;
`endif
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         s0    <= 1'b0;
         s1    <= 1'b0;
         lvl_q <= 1'b0;
         press <= 1'b0;
      end else begin
         s0    <= btn;
         s1    <= s0;
         lvl_q <= lvl;
         press <= lvl & ~lvl_q;
      end
   end
endmodule

// File: rtl/launch_ctrl.sv
// launch_ctrl: aim/power launch stage feeding the ball physics block.
//   clk_in               clock
//   rst_in               asynchronous active-low reset
//   btn_left/right/fire  raw buttons, active-high
//   ball                 launch_ctrl_if.master: speeds, sign, valid, ball done
//   aim_out              signed aim for the HUD
//   power_out            current power for the HUD
//   state_out            AIM=0, POWER=1, LAUNCH=2, ROLL=3
// Macro LAUNCH_CTRL_DEBOUNCE_EN enables button debounce.
module launch_ctrl
   import launch_ctrl_pkg::*;
#(
   parameter int TICK_CYCLES     = 3000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int MIN_SPEED       = 1,
   parameter int MAX_SPEED       = 16,
   parameter int MAX_ANGLE       = 8
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      btn_left,
   input  logic                      btn_right,
   input  logic                      btn_fire,
   launch_ctrl_if.master             ball,
   output logic signed [AIM_W-1:0]   aim_out,
   output logic [POWER_W-1:0]        power_out,
   output logic [1:0]                state_out
);
   localparam int CW = $clog2(TICK_CYCLES + 1);
   localparam logic signed [AIM_W-1:0] AIM_HI = AIM_W'(MAX_ANGLE);
   localparam logic signed [AIM_W-1:0] AIM_LO = -AIM_W'(MAX_ANGLE);
   localparam logic [POWER_W-1:0] P_MIN = POWER_W'(MIN_SPEED);
   localparam logic [POWER_W-1:0] P_MAX = POWER_W'(MAX_SPEED);
   state_t        state;
   logic [CW-1:0] cnt;
   logic          dir_up, done_q, done_rise, up;
   logic          p_l, p_r, p_f;
   launch_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left  (.clk_in(clk_in), .rst_in(rst_in), .btn(btn_left),  .press(p_l));
   launch_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (.clk_in(clk_in), .rst_in(rst_in), .btn(btn_right), .press(p_r));
   launch_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire  (.clk_in(clk_in), .rst_in(rst_in), .btn(btn_fire),  .press(p_f));
   assign state_out = state;
   // ping-pong: keep climbing until the top, keep falling until the bottom
   assign up = dir_up ? (power_out != P_MAX) : (power_out == P_MIN);
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state              <= AIM;
         cnt                <= '0;
         dir_up             <= 1'b1;
         done_q             <= 1'b0;
         done_rise          <= 1'b0;
         aim_out            <= '0;
         power_out          <= P_MIN;
         ball.speed_x_out   <= '0;
         ball.speed_y_out   <= '0;
         ball.is_vy_neg_out <= 1'b0;
         ball.valid_out     <= 1'b0;
      end else begin
         done_q    <= ball.ball_done_in;
         done_rise <= ball.ball_done_in & ~done_q;
         case (state)
            AIM: begin
               if (p_f) begin
                  state <= POWER;
                  cnt   <= '0;
               end else if (p_l & ~p_r) begin
                  aim_out <= (aim_out == AIM_LO) ? aim_out : aim_out - 1'b1;
               end else if (p_r & ~p_l) begin
                  aim_out <= (aim_out == AIM_HI) ? aim_out : aim_out + 1'b1;
               end
            end
            POWER: begin
               if (p_f) begin
                  state              <= LAUNCH;
                  cnt                <= '0;
                  ball.speed_x_out   <= SPEED_W'(power_out);
                  ball.speed_y_out   <= launch_vy(aim_out, power_out);
                  ball.is_vy_neg_out <= aim_out[AIM_W-1];
                  ball.valid_out     <= 1'b1;
               end else if (cnt == CW'(TICK_CYCLES - 1)) begin
                  cnt <= '0;
                  if (MIN_SPEED != MAX_SPEED) begin
                     power_out <= up ? power_out + 1'b1 : power_out - 1'b1;
                     dir_up    <= up;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LAUNCH: begin
               // valid spans TICK_CYCLES+1 cycles so the ball's tick always lands inside it
               if (cnt == CW'(TICK_CYCLES)) begin
                  state          <= ROLL;
                  ball.valid_out <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ROLL: begin
               if (done_rise) begin
                  state     <= AIM;
                  power_out <= P_MIN;
                  dir_up    <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_launch_ctrl.sv
// tb_launch_ctrl: directed scoreboard bench for launch_ctrl.
module tb_launch_ctrl;
   import launch_ctrl_pkg::*;
   localparam int TICK = 4, DEB = 2, MAXA = 3, MINS = 1, MAXS = 4;
`ifdef LAUNCH_CTRL_DEBOUNCE_EN
   localparam int LAT = 3 + DEB;
   localparam logic [15:0] GLITCH_STATE = 16'd0;
`else
   localparam int LAT = 3;
   localparam logic [15:0] GLITCH_STATE = 16'd1;
`endif
   localparam int H = LAT + 1;
   logic clk_in = 1'b0, rst_in = 1'b0;
   logic btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
   logic [4:0] aim_out;
   logic [4:0] power_out;
   logic [1:0] state_out;
   int checks = 0, errors = 0, n;
   logic [15:0] exp_q[$];
   string tag_q[$];
   int pp[7] = '{2, 3, 4, 3, 2, 1, 2};
   launch_ctrl_if bus();
   launch_ctrl #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .MIN_SPEED(MINS), .MAX_SPEED(MAXS), .MAX_ANGLE(MAXA)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
      .ball(bus), .aim_out(aim_out), .power_out(power_out), .state_out(state_out));
   always #5 clk_in = ~clk_in;
   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog");
   end
   task automatic tick(input int k);
      repeat (k) @(posedge clk_in);
      #1;
   endtask
   task automatic expect_val(input string t, input logic [15:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask
   task automatic check(input logic [15:0] obs);
      logic [15:0] e;
      string t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed=%0d expected=queued value", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
         end
      end
   endtask
   task automatic press(input logic l, input logic r, input logic f);
      btn_left = l; btn_right = r; btn_fire = f;
      tick(H);
      btn_left = 0; btn_right = 0; btn_fire = 0;
      tick(H);
   endtask
   initial begin
      bus.ball_done_in = 1'b0;
      tick(2);
      expect_val("rst_state", 0); check(16'(state_out));
      expect_val("rst_aim", 0);   check(16'(aim_out));
      expect_val("rst_power", 1); check(16'(power_out));
      expect_val("rst_valid", 0); check(16'(bus.valid_out));
      rst_in = 1'b1;
      tick(1);
      repeat (5) press(0, 1, 0);
      expect_val("aim_clamp_hi", 3); check(16'(aim_out));
      repeat (7) press(1, 0, 0);
      expect_val("aim_clamp_lo", 29); check(16'(aim_out));
      press(1, 1, 0);
      expect_val("aim_both", 29); check(16'(aim_out));
      press(0, 1, 0);
      expect_val("aim_m2", 30); check(16'(aim_out));
      expect_val("enter_power", 1); expect_val("power0", 1);
      btn_fire = 1'b1;
      tick(H);
      check(16'(state_out)); check(16'(power_out));
      btn_fire = 1'b0;
      for (int i = 0; i < 7; i++) begin
         expect_val($sformatf("power%0d", i + 1), 16'(pp[i]));
         tick(TICK);
         check(16'(power_out));
      end
      tick(2);
      expect_val("launch_state", 2); expect_val("speed_x", 3); expect_val("speed_y", 1);
      expect_val("vy_neg", 1); expect_val("valid_rise", 1);
      btn_fire = 1'b1;
      bus.ball_done_in = 1'b1;
      tick(H);
      check(16'(state_out)); check(bus.speed_x_out); check(bus.speed_y_out);
      check(16'(bus.is_vy_neg_out)); check(16'(bus.valid_out));
      btn_fire = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus.valid_out) break;
         n++;
         tick(1);
      end
      expect_val("valid_len", 16'(TICK + 1)); check(16'(n));
      expect_val("roll_state", 3); check(16'(state_out));
      tick(6);
      expect_val("done_level", 3); check(16'(state_out));
      press(1, 0, 0);
      press(0, 0, 1);
      expect_val("roll_ignore_state", 3); check(16'(state_out));
      expect_val("roll_ignore_aim", 30);  check(16'(aim_out));
      bus.ball_done_in = 1'b0;
      tick(2);
      expect_val("rearm_wait", 3); expect_val("rearm_state", 0); expect_val("rearm_power", 1);
      expect_val("rearm_aim", 30); expect_val("speed_x_hold", 3);
      bus.ball_done_in = 1'b1;
      tick(1);
      check(16'(state_out));
      tick(1);
      check(16'(state_out)); check(16'(power_out)); check(16'(aim_out)); check(bus.speed_x_out);
      expect_val("glitch", GLITCH_STATE);
      btn_fire = 1'b1;
      tick(1);
      btn_fire = 1'b0;
      tick(LAT + 3);
      check(16'(state_out));
`ifdef LAUNCH_CTRL_DEBOUNCE_EN
      press(0, 0, 1);
`endif
      expect_val("launch2_valid", 1);
      btn_fire = 1'b1;
      tick(H);
      check(16'(bus.valid_out));
      expect_val("async_valid", 0); expect_val("async_state", 0); expect_val("async_aim", 0);
      expect_val("async_power", 1); expect_val("async_speed_x", 0);
      #2 rst_in = 1'b0;
      #1;
      check(16'(bus.valid_out)); check(16'(state_out)); check(16'(aim_out));
      check(16'(power_out)); check(bus.speed_x_out);
      btn_fire = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/launch_ctrl.md
# launch_ctrl

Player-facing launch stage directly upstream of the ball physics block. Turns three raw push-buttons into an aim angle and an oscillating power value. On fire, it presents speed_x, speed_y, vy sign and a held valid strobe to the ball block. It then waits for the ball's done before re-arming.

## Interface
- TICK_CYCLES, 3000000: power-meter step period in clk_in cycles; equals the ball block's update period.
- DEBOUNCE_CYCLES, 1000000: cycles a synchronized button must stay stable before a level change is accepted.
- MIN_SPEED, 1: lowest power value, 1..MAX_SPEED.
- MAX_SPEED, 16: highest power value, ≤ 31.
- MAX_ANGLE, 8: aim magnitude limit, ≤ 15.
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- btn_left / btn_right / btn_fire  input  1 each  raw asynchronous buttons, active-high.
- ball_done_in  input  1  ball block's done.
- speed_x_out  output  16  horizontal speed to ball.
- speed_y_out  output  16  vertical speed magnitude to ball.
- is_vy_neg_out  output  1  vertical direction to ball; 1 = upward.
- valid_out  output  1  launch request to ball.
- aim_out  output  5  signed aim for the HUD.
- power_out  output  5  current power for the HUD.
- state_out  output  2  FSM state: AIM=0, POWER=1, LAUNCH=2, ROLL=3.

## Operation
- Each button path: 2-FF synchronizer, then debounce, then rising-edge detect. This yields a one-cycle press pulse.
- State AIM:
  - left press: aim -= 1, saturating at -MAX_ANGLE.
  - right press: aim += 1, saturating at +MAX_ANGLE.
  - left and right in the same cycle: no change.
  - fire press: go to POWER. Fire has priority over left/right in the same cycle; aim is unchanged.
- State POWER:
  - power starts at MIN_SPEED, direction up.
  - Every TICK_CYCLES, power steps by 1 and ping-pongs. It reaches MAX_SPEED, then continues MAX_SPEED-1, and so on down to MIN_SPEED, then turns up again.
  - fire press: latch the outputs and go to LAUNCH. The tick counter and left/right are ignored in that cycle.
- Latched outputs:
  - speed_x_out = power, zero-extended.
  - speed_y_out = (|aim| × power) >> 2, computed at 10 bits and zero-extended.
  - is_vy_neg_out = aim < 0.
- State LAUNCH:
  - valid_out is held high for exactly TICK_CYCLES+1 cycles. This guarantees the ball block samples it on one of its tick cycles, since the ball has no acknowledge.
  - Then go to ROLL.
- State ROLL:
  - Wait for a rising edge of ball_done_in, detected against a registered copy.
  - Then return to AIM. Power resets to MIN_SPEED and direction to up; aim is retained.
  - Button presses in LAUNCH and ROLL are discarded.
- speed/sign outputs hold their latched values from the latch cycle until the next latch.

## Timing
- Reset: while rst_in is low, all outputs are forced 0 immediately (no clock needed), except power_out = MIN_SPEED. State = AIM, aim = 0, tick/debounce counters cleared, edge registers cleared.
- Reset asserted mid-LAUNCH: valid_out drops asynchronously.
- Button latency: 2 cycles of sync, plus DEBOUNCE_CYCLES of stability, plus 1 cycle of edge detect. The press pulse is therefore seen 3+DEBOUNCE_CYCLES cycles after a clean edge.
- Transitions register on the clock edge after the press pulse.
- Fire in POWER to valid_out high: 1 cycle. Outputs and valid_out rise in the same cycle.
- ball_done_in rising edge to state_out = AIM: 2 cycles (edge register plus state register).
- The tick counter runs only in POWER. It is cleared on entry, so the first step occurs TICK_CYCLES cycles after entering POWER.
- If MIN_SPEED == MAX_SPEED, power stays constant.

## Configuration
- LAUNCH_CTRL_DEBOUNCE_EN
  - Defined: debounce stage present as described.
  - Undefined: debounce bypassed; the edge detector sees the synchronizer output directly. Button latency becomes 3 cycles, and DEBOUNCE_CYCLES is unused.

## Structure
- The shared game package holds:
  - the FSM state enum (AIM/POWER/LAUNCH/ROLL, 2-bit);
  - the aim and power widths (5);
  - the speed bus width (16, shared with the ball block).
- One sub-module, btn_debounce: synchronizer, optional debounce counter and rising-edge pulse output. It is instantiated three times.

## Test plan
Bench parameters: TICK_CYCLES=4, DEBOUNCE_CYCLES=2, MAX_ANGLE=3, MIN_SPEED=1, MAX_SPEED=4.
- Reset behaviour: drop rst_in mid-cycle while in LAUNCH -> valid_out=0 with no clock edge. state_out=0, aim_out=0, power_out=1.
- Aim clamp and simultaneity:
  - 5 right presses -> aim_out=3.
  - 7 left presses -> aim_out=-3 (5'b11101).
  - left+right together -> unchanged.
- Power ping-pong: fire to POWER, sample every 4 cycles -> power_out 1,2,3,4,3,2,1,2.
- Launch latch: aim=-2, fire at power=3.
  - speed_x_out=3, speed_y_out=1, is_vy_neg_out=1.
  - valid_out high exactly 5 cycles, then state_out=3.
- Rearm: in ROLL, hold ball_done_in high (no edge) -> stays ROLL. Pulse 0->1 -> state_out=0 two cycles later, power_out=1, aim_out=-2.
- Press filtering:
  - glitch btn_fire for 1 cycle -> no transition.
  - with the macro undefined, the same glitch -> AIM to POWER.
  - presses during ROLL -> ignored.
